// File: rtl/sonic_echo_model.sv
`default_nettype none
// ============================================================================
// Module   : sonic_echo_model
// Purpose  : HC-SR04 style ranger emulator; answers a trig pulse with an echo
//            pulse whose width encodes a programmed distance.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_echo_model #(
    parameter int CLK_PER_US  = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 59,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [5:0] distance,
    input  logic       no_object,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST   = PRE_W'(CLK_PER_US - 1);
    localparam logic [15:0]      C_TRIG_MIN   = 16'(TRIG_MIN_US);
    localparam logic [15:0]      C_BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]      C_HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]      C_TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0]      C_US_PER_CM  = 16'(US_PER_CM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_trig_s;
    logic             r_trig_d;
    logic [1:0]       r_warm;
    logic             r_armed;
    logic [PRE_W-1:0] r_pre;
    logic [15:0]      r_us;
    logic [15:0]      r_width;
    logic             w_tick;
    logic             w_err;
    logic             w_change;
    logic [15:0]      w_prod;
    logic [15:0]      w_width;
    logic [15:0]      w_width_last;

    // r_armed only sets once a genuine low level has crossed the synchronizer,
    // so a trig held high through reset release is never seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_trig_s <= 1'b0;
            r_trig_d <= 1'b0;
            r_warm   <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            r_sync1  <= trig;
            r_trig_s <= r_sync1;
            r_trig_d <= r_trig_s;
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end else if (!r_trig_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_tick       = (r_pre == C_PRE_LAST);
    assign w_change     = (w_next != r_state);
    assign w_prod       = 16'(distance) * C_US_PER_CM;
    assign w_width      = no_object ? C_TIMEOUT : ((w_prod == 16'd0) ? 16'd1 : w_prod);
    assign w_width_last = r_width - 16'd1;

    // Timebase restarts on every transition so each interval is cycle exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_us  <= 16'd0;
        end else if (w_change) begin
            r_pre <= '0;
            r_us  <= 16'd0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && (r_us != 16'hFFFF)) begin
                r_us <= r_us + 16'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_trig_s && !r_trig_d && r_armed) begin
                    w_next = S_TRIG_HI;
                end
            end
            S_TRIG_HI: begin
                if (!r_trig_s) begin
                    if (r_us >= C_TRIG_MIN) begin
                        w_next = S_BURST;
                    end else begin
                        w_next = S_IDLE;
                        w_err  = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (w_tick && (r_us == C_BURST_LAST)) begin
                    w_next = S_ECHO;
                end
            end
            S_ECHO: begin
                if (w_tick && (r_us == w_width_last)) begin
                    w_next = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (w_tick && (r_us == C_HOLD_LAST)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_width  <= 16'd0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            r_state  <= w_next;
            echo     <= (w_next == S_ECHO);
            busy     <= (w_next != S_IDLE);
            trig_err <= w_err;
            if ((r_state == S_TRIG_HI) && (w_next == S_BURST)) begin
                r_width <= w_width;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sonic_echo_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_echo_model
// Purpose  : Randomized self-checking bench for sonic_echo_model (scaled timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonic_echo_model;
    localparam int C  = 4;
    localparam int T  = 3;
    localparam int B  = 5;
    localparam int U  = 3;
    localparam int TO = 250;
    localparam int H  = 20;
    localparam int BUDGET = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [5:0] distance = 6'd0;
    logic       no_object = 1'b0;
    logic       echo, busy, trig_err;

    int total = 0;
    int bad   = 0;

    sonic_echo_model #(
        .CLK_PER_US(C), .TRIG_MIN_US(T), .BURST_US(B),
        .US_PER_CM(U), .TIMEOUT_US(TO), .HOLDOFF_US(H)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .distance(distance),
        .no_object(no_object), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge recorder for the DUT outputs, sampled on the falling clock edge
    logic echo_q = 1'b0, busy_q = 1'b0;
    int n_rise = 0, n_fall = 0, rise_cyc = 0, fall_cyc = 0;
    int err_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, n_busy_fall = 0;
    always @(negedge clk) begin
        if (echo && !echo_q) begin n_rise++; rise_cyc = cyc; end
        if (!echo && echo_q) begin n_fall++; fall_cyc = cyc; end
        if (trig_err) err_cyc++;
        if (busy && !busy_q) busy_rise_cyc = cyc;
        if (!busy && busy_q) begin n_busy_fall++; busy_fall_cyc = cyc; end
        echo_q = echo;
        busy_q = busy;
    end

    // Reference: echo width in clocks from the programmed target
    function automatic int exp_width(input int d, input bit no);
        int us;
        us = no ? TO : d * U;
        if (us < 1) us = 1;
        return us * C;
    endfunction

    task automatic pulse(input int n, output int rise_at, output int fall_at);
        @(posedge clk); #1;
        trig = 1'b1; rise_at = cyc;
        repeat (n) @(posedge clk);
        #1;
        trig = 1'b0; fall_at = cyc;
    endtask

    task automatic run_req(input int d, input bit no, input int n, input bit mid_change,
                           output int lat, output int width, output int tail,
                           output int blat, output int rises, output int errs, output bit ok);
        int r0, e0, f0, bf0, ra, fa;
        r0 = n_rise; e0 = err_cyc; f0 = n_fall; bf0 = n_busy_fall;
        distance = 6'(d); no_object = no;
        pulse(n, ra, fa);
        if (mid_change) begin
            for (int i = 0; i < BUDGET && n_rise == r0; i++) @(negedge clk);
            repeat (2) @(negedge clk);
            distance = 6'($urandom_range(0, 63));
            no_object = ~no;
        end
        for (int i = 0; i < BUDGET && n_fall == f0; i++) @(negedge clk);
        for (int i = 0; i < BUDGET && n_busy_fall == bf0; i++) @(negedge clk);
        ok    = (n_fall > f0) && (n_busy_fall > bf0);
        lat   = rise_cyc - fa;
        width = fall_cyc - rise_cyc;
        tail  = busy_fall_cyc - fall_cyc;
        blat  = busy_rise_cyc - ra;
        rises = n_rise - r0;
        errs  = err_cyc - e0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trig = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (echo !== 1'b0) begin bad++; $display("FAIL reset_echo got=%b want=0", echo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (trig_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", trig_err); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b want=0", busy); end
    endtask

    task automatic test_random_ranges();
        int d, n, lat, w, tail, blat, rises, errs;
        bit no, ok;
        for (int k = 0; k < 6; k++) begin
            d  = $urandom_range(0, 63);
            no = ($urandom_range(0, 4) == 0);
            n  = $urandom_range(T*C + 2, T*C + 12);
            run_req(d, no, n, 1'b1, lat, w, tail, blat, rises, errs, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_timeout iter=%0d", k); end
            total++; if (w != exp_width(d, no)) begin bad++; $display("FAIL rand_width d=%0d no=%0d got=%0d want=%0d", d, no, w, exp_width(d, no)); end
            total++; if (lat < B*C + 2 || lat > B*C + 4) begin bad++; $display("FAIL rand_latency got=%0d want=%0d+-1", lat, B*C + 3); end
            total++; if (tail != H*C) begin bad++; $display("FAIL rand_holdoff got=%0d want=%0d", tail, H*C); end
            total++; if (blat < 2 || blat > 4) begin bad++; $display("FAIL rand_busy_rise got=%0d want=3+-1", blat); end
            total++; if (rises != 1 || errs != 0) begin bad++; $display("FAIL rand_counts rises=%0d errs=%0d want 1/0", rises, errs); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_boundaries();
        int lat, w, tail, blat, rises, errs;
        bit ok;
        run_req(0, 1'b0, T*C + 4, 1'b0, lat, w, tail, blat, rises, errs, ok);
        total++; if (!ok || w != C) begin bad++; $display("FAIL dist0_width got=%0d want=%0d ok=%0d", w, C, ok); end
        run_req(63, 1'b0, T*C + 4, 1'b1, lat, w, tail, blat, rises, errs, ok);
        total++; if (!ok || w != 63*U*C) begin bad++; $display("FAIL dist63_width got=%0d want=%0d ok=%0d", w, 63*U*C, ok); end
        total++; if (tail != H*C) begin bad++; $display("FAIL dist63_busy_tail got=%0d want=%0d", tail, H*C); end
        run_req(20, 1'b1, T*C + 4, 1'b1, lat, w, tail, blat, rises, errs, ok);
        total++; if (!ok || w != TO*C) begin bad++; $display("FAIL noobj_width got=%0d want=%0d ok=%0d", w, TO*C, ok); end
    endtask

    task automatic test_short_trig();
        int n, r0, e0, ra, fa, lat, w, tail, blat, rises, errs;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, T*C - 2);
            r0 = n_rise; e0 = err_cyc;
            pulse(n, ra, fa);
            repeat (8) @(negedge clk);
            total++; if (err_cyc - e0 != 1) begin bad++; $display("FAIL short_err_cycles n=%0d got=%0d want=1", n, err_cyc - e0); end
            total++; if (n_rise != r0 || busy !== 1'b0) begin bad++; $display("FAIL short_no_echo rises=%0d busy=%b want 0/0", n_rise - r0, busy); end
        end
        run_req(7, 1'b0, T*C + 2, 1'b0, lat, w, tail, blat, rises, errs, ok);
        total++; if (!ok || w != exp_width(7, 1'b0) || errs != 0) begin bad++; $display("FAIL after_short width=%0d want=%0d errs=%0d", w, exp_width(7, 1'b0), errs); end
    endtask

    task automatic test_back_to_back();
        int r0, f0, ra, fa, tgt;
        bit ok;
        r0 = n_rise; f0 = n_fall;
        distance = 6'd10; no_object = 1'b0;
        pulse(T*C + 4, ra, fa);
        for (int i = 0; i < BUDGET && n_rise == r0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        pulse(T*C + 4, ra, fa);
        for (int i = 0; i < BUDGET && n_fall == f0; i++) @(negedge clk);
        ok = (n_fall > f0);
        repeat (4) @(negedge clk);
        pulse(T*C + 4, ra, fa);
        tgt = fall_cyc + H*C - 6;
        for (int i = 0; i < BUDGET && cyc < tgt; i++) @(negedge clk);
        pulse(30, ra, fa);
        repeat (200) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout no echo fall"); end
        total++; if (n_rise - r0 != 1) begin bad++; $display("FAIL b2b_extra_echo got=%0d want=1", n_rise - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        int r0, ra, fa, lat, w, tail, blat, rises, errs;
        bit ok;
        r0 = n_rise;
        distance = 6'd30; no_object = 1'b0;
        pulse(T*C + 4, ra, fa);
        for (int i = 0; i < BUDGET && n_rise == r0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; trig = 1'b1;
        #1;
        total++; if (echo !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL async_rst echo=%b busy=%b want 0/0", echo, busy); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        r0 = n_rise;
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0 || n_rise != r0) begin bad++; $display("FAIL held_trig busy=%b rises=%0d want 0/0", busy, n_rise - r0); end
        trig = 1'b0;
        repeat (10) @(negedge clk);
        run_req(5, 1'b0, T*C + 4, 1'b0, lat, w, tail, blat, rises, errs, ok);
        total++; if (!ok || w != exp_width(5, 1'b0) || rises != 1) begin bad++; $display("FAIL post_rst width=%0d want=%0d rises=%0d", w, exp_width(5, 1'b0), rises); end
    endtask

    initial begin
        test_reset();
        test_random_ranges();
        test_boundaries();
        test_short_trig();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
